// File: rtl/ram_pkg.sv
// Shared sizing and word/address types for the single-port RAM and its bench.
package ram_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/modport_ram.sv
// Single-port synchronous RAM: shared address, separate write/read enables,
// registered read-first data output, whole-array synchronous clear on reset.
module modport_ram
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH = ram_pkg::WIDTH,
  parameter int unsigned DEPTH = ram_pkg::DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic                            rd_en,
  input  logic [WIDTH-1:0]                data_in,
  input  logic [$clog2(DEPTH)-1:0]        address,
  output logic [WIDTH-1:0]                data_out
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range_c;

  // Address guard: only a non-power-of-two depth can see addresses past the end.
  generate
    if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
      assign in_range_c = 1'b1;
    end else begin : g_partial_range
      assign in_range_c = (32'(address) < DEPTH);
    end
  endgenerate

  // Storage, write port and read-first registered read port; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (rd_en) begin
        data_out <= in_range_c ? mem[address] : '0;
      end
      if (wr_en && in_range_c) begin
        mem[address] <= data_in;
      end
    end
  end

endmodule : modport_ram

// File: tb/tb_modport_ram.sv
// Self-checking bench for modport_ram: directed vector table, hand-written
// back-to-back sequence, then randomized traffic against an array model.
module tb_modport_ram;
  import ram_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  wr_en;
  logic  rd_en;
  word_t data_in;
  addr_t address;
  word_t data_out;

  always #5 clk = ~clk;

  modport_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out)
  );

  typedef struct {
    logic  r;
    logic  w;
    logic  rd;
    addr_t a;
    word_t d;
    word_t exp;
  } vec_t;

  vec_t  vecs[$];
  int    total = 0;
  int    bad   = 0;
  word_t ref_mem [DEPTH];
  word_t ref_out;

  task automatic add(input logic r, input logic w, input logic rd,
                     input int a, input int d, input int e);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd;
    v.a = addr_t'(a); v.d = word_t'(d); v.exp = word_t'(e);
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic apply(input logic r, input logic w, input logic rd,
                       input addr_t a, input word_t d);
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; address = a; data_in = d;
    @(posedge clk);
    if (r) begin
      ref_out = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      if (rd) ref_out = ref_mem[a];
      if (w)  ref_mem[a] = d;
    end
    #1;
  endtask

  task automatic check(input string name, input word_t exp);
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: data_out=%h expected=%h at %0t", name, data_out, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; data_in = '0;
    ref_out = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset two cycles, then read every address.
    add(1, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) add(0, 0, 1, i, 0, 8'h00);
    // Write/read-back.
    add(0, 1, 0, 3, 8'hA5, 8'h00);
    add(0, 1, 0, 15, 8'h3C, 8'h00);
    add(0, 0, 1, 3, 0, 8'hA5);
    add(0, 0, 1, 15, 0, 8'h3C);
    add(0, 0, 1, 4, 0, 8'h00);
    add(0, 0, 1, 14, 0, 8'h00);
    // Read-first collision.
    add(0, 1, 0, 7, 8'h11, 8'h00);
    add(0, 1, 1, 7, 8'h22, 8'h11);
    add(0, 0, 1, 7, 0, 8'h22);
    // Hold while writing the read location.
    add(0, 0, 1, 3, 0, 8'hA5);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 3, 8'hFF, 8'hA5);
    add(0, 0, 1, 3, 0, 8'hFF);
    // Fill with 0x5A, then reset concurrent with a write.
    for (int i = 0; i < 16; i++) add(0, 1, 0, i, 8'h5A, 8'hFF);
    add(0, 0, 1, 9, 0, 8'h5A);
    add(1, 1, 0, 0, 8'h99, 8'h00);
    for (int i = 0; i < 16; i++) add(0, 0, 1, i, 0, 8'h00);

    foreach (vecs[k]) begin
      apply(vecs[k].r, vecs[k].w, vecs[k].rd, vecs[k].a, vecs[k].d);
      check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Back-to-back alternating write/read, no idle cycles.
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, 1'b0, addr_t'(i), word_t'(i * 8'h11));
      apply(1'b0, 1'b0, 1'b1, addr_t'(i), 8'h00);
      check($sformatf("b2b%0d", i), word_t'(i * 8'h11));
    end

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      logic r, w, rd;
      r  = ($urandom_range(0, 59) == 0);
      w  = 1'($urandom);
      rd = 1'($urandom);
      apply(r, w, rd, addr_t'($urandom), word_t'($urandom));
      check($sformatf("rand%0d", n), ref_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_modport_ram
